eleven_bit_down_timer: RTL and testbench

Loadable 11-bit countdown timer for the reaction-time game. It complements the free-running up-counter used to measure the player's response. The game controller loads a random delay and enables the timer. When the count reaches zero, the timer emits a one-cycle Done pulse, which the controller uses to light the "go" LED. A prescaler scales the count rate, and the timer supports pause, abort and restart.

---
 rtl/eleven_bit_down_timer_pkg.sv | 13 +
 rtl/eleven_bit_down_timer_timer_prescaler.sv | 30 +++
 rtl/eleven_bit_down_timer.sv | 96 +++++++++
 tb/tb_eleven_bit_down_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/eleven_bit_down_timer_pkg.sv
// Shared types and constants for the eleven_bit_down_timer and its prescaler.
package eleven_bit_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 11;
  localparam int PRESCALE_W    = 16;

endpackage

// File: rtl/eleven_bit_down_timer_timer_prescaler.sv
// Enable-qualified modulo-PRESCALE counter with synchronous clear.
// Emits a single-cycle tick on the last enabled cycle of each period.
module timer_prescaler
  import eleven_bit_down_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/eleven_bit_down_timer.sv
// Loadable countdown timer with prescaler, pause, abort and restart.
// Optional auto-reload on terminal count: define DOWN_TIMER_AUTORELOAD_EN.
module eleven_bit_down_timer
  import eleven_bit_down_timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Enable,
  input  logic             Abort,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Expired
);

  state_t state;
  logic   tick;
  logic   run_en;
  logic   presc_clear;

`ifdef DOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  assign run_en      = (state == RUN) && Enable;
  assign presc_clear = Load || Abort;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (Clock),
    .reset  (Reset),
    .clear  (presc_clear),
    .enable (run_en),
    .tick   (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      Count   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Expired <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload  <= '0;
`endif
    end else begin
      Done <= 1'b0;
      if (Abort) begin
        state   <= IDLE;
        Count   <= '0;
        Busy    <= 1'b0;
        Expired <= 1'b0;
      end else if (Load) begin
        // A tick coinciding with Load is dropped: the new value wins.
        if (LoadValue != '0) begin
          state   <= RUN;
          Count   <= LoadValue;
          Busy    <= 1'b1;
          Expired <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
          reload  <= LoadValue;
`endif
        end else begin
          state   <= EXPIRED;
          Count   <= '0;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          Expired <= 1'b1;
        end
      end else if ((state == RUN) && tick) begin
        if (Count > WIDTH'(1)) begin
          Count <= Count - WIDTH'(1);
        end else begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
          Count <= reload;
          Done  <= 1'b1;
`else
          state   <= EXPIRED;
          Count   <= '0;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          Expired <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_eleven_bit_down_timer.sv
// Directed bench: one-cycle vector table plus hand-written multi-cycle sequences.
// Two instances share stimulus: PRESCALE=1 (dut1) and PRESCALE=4 (dut4).
module tb_eleven_bit_down_timer;

  logic        Clock = 1'b0;
  logic        Reset, Load, Enable, Abort;
  logic [10:0] LoadValue;

  logic [10:0] count1, count4;
  logic        busy1, done1, expired1;
  logic        busy4, done4, expired4;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  eleven_bit_down_timer #(.WIDTH(11), .PRESCALE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Load(Load), .LoadValue(LoadValue),
    .Enable(Enable), .Abort(Abort),
    .Count(count1), .Busy(busy1), .Done(done1), .Expired(expired1)
  );

  eleven_bit_down_timer #(.WIDTH(11), .PRESCALE(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Load(Load), .LoadValue(LoadValue),
    .Enable(Enable), .Abort(Abort),
    .Count(count4), .Busy(busy4), .Done(done4), .Expired(expired4)
  );

  typedef struct {
    logic        rst;
    logic        ld;
    logic [10:0] val;
    logic        en;
    logic        ab;
    logic [10:0] count;
    logic        busy;
    logic        done;
    logic        expired;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check1(input string tag, input int c, input int b, input int d, input int e);
    check({tag, "_count"},   int'(count1),   c);
    check({tag, "_busy"},    int'(busy1),    b);
    check({tag, "_done"},    int'(done1),    d);
    check({tag, "_expired"}, int'(expired1), e);
  endtask

  // Apply inputs, let one rising edge pass, then settle before sampling.
  task automatic cycle(input logic rst, input logic ld, input logic [10:0] val,
                       input logic en, input logic ab);
    Reset = rst; Load = ld; LoadValue = val; Enable = en; Abort = ab;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  vec_t vecs[17];

  initial begin
    Reset = 1'b1; Load = 1'b0; LoadValue = '0; Enable = 1'b0; Abort = 1'b0;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    do_reset();
    check1("ar_reset", 0, 0, 0, 0);
    cycle(1'b0, 1'b1, 11'd3, 1'b1, 1'b0);
    check1("ar_load", 3, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
      check1($sformatf("ar_k%0d", k), 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0, 0);
    end
    cycle(1'b0, 1'b1, 11'd0, 1'b1, 1'b0);
    check1("ar_load0", 0, 0, 1, 1);
`else
    // rst, ld, val, en, ab | count, busy, done, expired
    vecs[0]  = '{1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd4, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd3, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd2, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 11'd4, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 11'd2, 1'b1, 1'b0, 11'd2, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd2, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 11'd6, 1'b1, 1'b0, 11'd6, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].rst, vecs[i].ld, vecs[i].val, vecs[i].en, vecs[i].ab);
      check1($sformatf("vec%0d", i), int'(vecs[i].count), int'(vecs[i].busy),
             int'(vecs[i].done), int'(vecs[i].expired));
    end

    // V=3, P=4: count steps every 4 cycles, Done 12 edges after the load edge.
    do_reset();
    cycle(1'b0, 1'b1, 11'd3, 1'b1, 1'b0);
    check("p4_load_count", int'(count4), 3);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
      check($sformatf("p4_k%0d_count", k), int'(count4), (k >= 12) ? 0 : 3 - k / 4);
      check($sformatf("p4_k%0d_done", k), int'(done4), (k == 12) ? 1 : 0);
    end
    check("p4_expired", int'(expired4), 1);
    check("p4_busy", int'(busy4), 0);

    // V=10, P=1, Enable low for 7 edges once Count reaches 7: Done moves from 10 to 17.
    do_reset();
    cycle(1'b0, 1'b1, 11'd10, 1'b1, 1'b0);
    begin
      int enabled_edges = 0;
      for (int k = 1; k <= 17; k++) begin
        logic en_k;
        en_k = !(k >= 4 && k <= 10);
        if (en_k) enabled_edges++;
        cycle(1'b0, 1'b0, 11'd0, en_k, 1'b0);
        check($sformatf("pause_k%0d_count", k), int'(count1), 10 - enabled_edges);
        check($sformatf("pause_k%0d_done", k), int'(done1), (k == 17) ? 1 : 0);
      end
    end
    check("pause_expired", int'(expired1), 1);

    // V=2047, abort at 1000: no Done ever; then Load 0 expires immediately.
    do_reset();
    cycle(1'b0, 1'b1, 11'd2047, 1'b1, 1'b0);
    begin
      int done_seen = 0;
      for (int k = 1; k <= 1047; k++) begin
        cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
        if (done1) done_seen++;
      end
      check("big_count_at_abort", int'(count1), 1000);
      check("big_done_before_abort", done_seen, 0);
    end
    cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b1);
    check1("big_abort", 0, 0, 0, 0);
    cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
    check1("big_idle_hold", 0, 0, 0, 0);
    cycle(1'b0, 1'b1, 11'd0, 1'b1, 1'b0);
    check1("big_load0", 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
    check1("big_load0_after", 0, 0, 0, 1);

    // V=8, re-load V=2 at Count=4: Done two edges after the re-load.
    do_reset();
    cycle(1'b0, 1'b1, 11'd8, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
    check("reld_count_before", int'(count1), 4);
    cycle(1'b0, 1'b1, 11'd2, 1'b1, 1'b0);
    check1("reld_load", 2, 1, 0, 0);
    cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
    check1("reld_k1", 1, 1, 0, 0);
    cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
    check1("reld_k2", 0, 0, 1, 1);

    // V=8, Reset at Count=3: everything clears and no Done follows.
    do_reset();
    cycle(1'b0, 1'b1, 11'd8, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
    check("rst_count_before", int'(count1), 3);
    cycle(1'b1, 1'b0, 11'd0, 1'b1, 1'b0);
    check1("rst_mid", 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
      check1($sformatf("rst_after_k%0d", k), 0, 0, 0, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
